fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch (IF) stage of the five-stage pipeline; first stage inside main.
- Owns the PC and issues requests to instruction memory through a valid/ready request channel and an in-order response channel.
- Buffers returned instructions and delivers {pc, instr} to the IF/ID boundary through a valid/ready handshake.
- Honours branch/jump redirects from EX by discarding stale in-flight responses.

Parameters:
- XLEN, 32, address/data width.
- RESET_PC, 32'h0000_0000, PC value after reset.
- DEPTH, 2, max in-flight requests plus buffered instructions (power of 2, >=2).

Ports:
- clk  in  1  pipeline clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  word-aligned fetch address.
- imem_rsp_valid  in  1  response valid; in order, >=1 cycle after acceptance.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  EX-stage taken branch/jump.
- redirect_pc  in  XLEN  redirect target.
- if_valid  out  1  instruction available to ID.
- if_ready  in  1  ID accepts (low = stall from hazard unit).
- if_pc  out  XLEN  PC of presented instruction.
- if_instr  out  32  presented instruction.

Behaviour:
- Reset:
  - pc_q = RESET_PC.
  - FIFO empty; outstanding = 0; drop_cnt = 0.
  - imem_req_valid = 0, if_valid = 0, if_pc = 0, if_instr = 32'h00000013 (NOP).
  - Reset mid-operation discards all state; responses to pre-reset requests are not expected.
- Credit rule: imem_req_valid = !rst && !redirect_valid && (outstanding + fifo_count < DEPTH). A response therefore always has a free FIFO slot.
- imem_req_addr = pc_q. On a request handshake: pc_q += 4 (wraps modulo 2^XLEN), outstanding++.
- Each request's PC is pushed into a PC tag queue on handshake; the tag is popped on the matching response.
- Response with drop_cnt == 0: push {tag, data} into the output FIFO.
- Response with drop_cnt > 0: discard it and decrement drop_cnt.
- Either response case decrements outstanding.
- Request and response in the same cycle: outstanding is unchanged.
- Output: if_valid = FIFO non-empty; if_pc/if_instr = FIFO head, combinational from the FIFO. Pop on if_valid && if_ready.
- Minimum latency: request accepted at cycle N, response at N+1, if_valid at N+2.
- Redirect (highest priority; the cycle's pop/push still occur):
  - pc_q <= {redirect_pc[XLEN-1:2], 2'b00}; bits [1:0] are ignored.
  - The output FIFO and the PC tag queue are flushed.
  - drop_cnt <= outstanding minus (1 if a response arrives in that cycle).
  - No request is issued in the redirect cycle.
  - if_valid is 0 from the following cycle until a post-redirect response arrives.
  - Back-to-back redirects: the last one wins; drop_cnt is recomputed each time.
- Stall (if_ready = 0): the FIFO holds, credits fill, and requests stop. No instruction is ever lost or duplicated.
- FIFO full and pop in the same cycle: the credit frees next cycle, not combinationally.
- Response when outstanding == 0: illegal. Ignore it and flag with a simulation-only $error.

Decomposition:
- pipeline_pkg:
  - constants XLEN, RESET_PC, NOP_INSTR = 32'h00000013.
  - IF/ID payload width (XLEN+32).
- Sub-module sync_fifo (parameters WIDTH, DEPTH):
  - push, pop, flush, count, head, full, empty.
  - Synchronous reset; flush takes priority over push.
  - Instantiated twice: output FIFO and PC tag queue.

Test Plan:
- Reset release, memory always ready, 1-cycle response returning addr^32'hA5A5_0000 → if_pc sequence 0,4,8,C…; first if_valid two cycles after the first handshake; if_instr matches.
- if_ready held low for 6 cycles → at most DEPTH requests accepted, imem_req_valid drops to 0; on release the PCs stream in order with no gap or duplicate.
- Two requests in flight (PC 8, C), redirect_valid to 32'h0000_0100 → both responses dropped, next imem_req_addr = 0x100, first if_pc = 0x100.
- Redirect to 32'h0000_0203 in the same cycle a response arrives → that response and the remaining in-flight response are dropped, fetch resumes at 0x200.
- imem_req_ready random 50% with 1–3 cycle response delay, 200 instructions → the delivered PC stream is contiguous.
- pc_q = 32'hFFFF_FFFC fetch → next imem_req_addr = 0; rst asserted mid-stream → the next cycle shows if_valid = 0, if_instr = NOP, imem_req_valid = 0, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: datapath width, reset vector and the NOP used
// to fill an empty IF/ID boundary.
package pipeline_pkg;

  localparam int              XLEN      = 32;
  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;
  localparam int              IFID_W    = XLEN + 32;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a flush that wins over a same-cycle push.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [WIDTH-1:0]         i_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [WIDTH-1:0]         o_head,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues credit-limited memory requests,
// buffers responses and drops stale ones after an EX redirect.
module fetch_stage #(
  parameter int              XLEN     = pipeline_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = pipeline_pkg::RESET_PC,
  parameter int              DEPTH    = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  output logic            o_imem_req_valid,
  input  logic            i_imem_req_ready,
  output logic [XLEN-1:0] o_imem_req_addr,
  input  logic            i_imem_rsp_valid,
  input  logic [31:0]     i_imem_rsp_data,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_if_valid,
  input  logic            i_if_ready,
  output logic [XLEN-1:0] o_if_pc,
  output logic [31:0]     o_if_instr
);

  import pipeline_pkg::*;

  localparam int          CW    = $clog2(DEPTH) + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

  logic [XLEN-1:0]  r_pc;
  logic [CW-1:0]    r_outstanding;
  logic [CW-1:0]    r_drop_cnt;

  logic [CW-1:0]    w_fifo_count;
  logic [CW-1:0]    w_tag_count;
  logic             w_fifo_empty;
  logic             w_fifo_full;
  logic             w_tag_empty;
  logic             w_tag_full;
  logic [XLEN+31:0] w_fifo_head;
  logic [XLEN-1:0]  w_tag_head;
  logic             w_req_fire;
  logic             w_rsp;
  logic             w_rsp_keep;
  logic             w_pop;
  logic             w_unused;

  // Credits cover in-flight requests plus buffered words, so every response has a slot.
  assign o_imem_req_valid = !i_rst && !i_redirect_valid &&
                            (({1'b0, r_outstanding} + {1'b0, w_fifo_count}) < LIMIT);
  assign o_imem_req_addr  = r_pc;
  assign w_req_fire       = o_imem_req_valid && i_imem_req_ready;
  assign w_rsp            = i_imem_rsp_valid && (r_outstanding != '0);
  assign w_rsp_keep       = w_rsp && (r_drop_cnt == '0);

  assign o_if_valid = !w_fifo_empty;
  assign w_pop      = o_if_valid && i_if_ready;
  assign o_if_pc    = o_if_valid ? w_fifo_head[XLEN+31:32] : '0;
  assign o_if_instr = o_if_valid ? w_fifo_head[31:0] : NOP_INSTR;

  assign w_unused = ^{w_fifo_full, w_tag_count, w_tag_empty, w_tag_full, i_redirect_pc[1:0]};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc          <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(w_rsp);
      if (i_redirect_valid) begin
        // Everything still in flight after this cycle belongs to the old path.
        r_pc       <= {i_redirect_pc[XLEN-1:2], 2'b00};
        r_drop_cnt <= r_outstanding - CW'(w_rsp);
      end else begin
        if (w_req_fire) begin
          r_pc <= r_pc + XLEN'(4);
        end
        if (w_rsp && (r_drop_cnt != '0)) begin
          r_drop_cnt <= r_drop_cnt - 1'b1;
        end
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge i_clk) begin
    if (!i_rst && i_imem_rsp_valid && (r_outstanding == '0)) begin
      $error("fetch_stage: instruction response with no outstanding request");
    end
  end
`endif

  sync_fifo #(
    .WIDTH (XLEN + 32),
    .DEPTH (DEPTH)
  ) u_out_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_rsp_keep),
    .i_pop   (w_pop),
    .i_flush (i_redirect_valid),
    .i_data  ({w_tag_head, i_imem_rsp_data}),
    .o_count (w_fifo_count),
    .o_head  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_req_fire),
    .i_pop   (w_rsp_keep),
    .i_flush (i_redirect_valid),
    .i_data  (r_pc),
    .o_count (w_tag_count),
    .o_head  (w_tag_head),
    .o_full  (w_tag_full),
    .o_empty (w_tag_empty)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: an in-order instruction memory with variable latency
// plus a stream-level model of the PC sequence that ID should observe.
module tb_fetch_stage;

  import pipeline_pkg::*;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] XORKEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reqValid;
  logic        reqReady = 1'b0;
  logic [31:0] reqAddr;
  logic        rspValid = 1'b0;
  logic [31:0] rspData = 32'h0;
  logic        redirectValid = 1'b0;
  logic [31:0] redirectPc = 32'h0;
  logic        ifValid;
  logic        ifReady = 1'b0;
  logic [31:0] ifPc;
  logic [31:0] ifInstr;

  always #5 clk = ~clk;

  fetch_stage #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000),
    .DEPTH    (DEPTH)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .o_imem_req_valid (reqValid),
    .i_imem_req_ready (reqReady),
    .o_imem_req_addr  (reqAddr),
    .i_imem_rsp_valid (rspValid),
    .i_imem_rsp_data  (rspData),
    .i_redirect_valid (redirectValid),
    .i_redirect_pc    (redirectPc),
    .o_if_valid       (ifValid),
    .i_if_ready       (ifReady),
    .o_if_pc          (ifPc),
    .o_if_instr       (ifInstr)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } memEntry_t;

  typedef struct {
    logic        ifRdy;
    logic        expReqValid;
    logic [31:0] expReqAddr;
    logic        expIfValid;
    logic [31:0] expIfPc;
  } vec_t;

  memEntry_t   memQ[$];
  vec_t        vecs[16];
  int          cyc = 0;
  int          lastDue = 0;
  int          memDelay = 1;
  bit          memRandom = 1'b0;
  bit          prevRedirect = 1'b0;
  int          errors = 0;
  int          checks = 0;
  int          delivered = 0;
  int          reqAccepts = 0;
  logic [31:0] expReqPc = 32'h0;
  logic [31:0] expNextPc = 32'h0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs and memory response, then score handshakes.
  task automatic applyStimulus(input logic ifRdy, input logic redir, input logic [31:0] redirPc);
    int d;
    int due;
    @(negedge clk);
    rst           = 1'b0;
    ifReady       = ifRdy;
    redirectValid = redir;
    redirectPc    = redirPc;
    reqReady      = memRandom ? 1'($urandom_range(0, 1)) : 1'b1;
    if (memQ.size() > 0 && memQ[0].due <= cyc) begin
      rspValid = 1'b1;
      rspData  = memQ[0].addr ^ XORKEY;
      void'(memQ.pop_front());
    end else begin
      rspValid = 1'b0;
      rspData  = $urandom();
    end
    #1;
    if (prevRedirect) checkOutput("ifValidAfterRedirect", 32'(ifValid), 32'd0);
    if (redir) checkOutput("reqValidInRedirect", 32'(reqValid), 32'd0);
    if (reqValid && reqReady) begin
      checkOutput("reqAddr", reqAddr, expReqPc);
      d   = memRandom ? int'($urandom_range(1, 3)) : memDelay;
      due = cyc + d;
      if (due <= lastDue) due = lastDue + 1;
      lastDue = due;
      memQ.push_back(memEntry_t'{addr: reqAddr, due: due});
      expReqPc = expReqPc + 32'd4;
      reqAccepts++;
    end
    if (ifValid && ifRdy) begin
      checkOutput("ifPc", ifPc, expNextPc);
      checkOutput("ifInstr", ifInstr, expNextPc ^ XORKEY);
      expNextPc = expNextPc + 32'd4;
      delivered++;
    end
    if (redir) begin
      expReqPc  = {redirPc[31:2], 2'b00};
      expNextPc = {redirPc[31:2], 2'b00};
    end
    prevRedirect = redir;
    cyc++;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst           = 1'b1;
    reqReady      = 1'b0;
    rspValid      = 1'b0;
    redirectValid = 1'b0;
    ifReady       = 1'b0;
    memQ.delete();
    expReqPc     = 32'h0;
    expNextPc    = 32'h0;
    prevRedirect = 1'b0;
    lastDue      = cyc;
    @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("rstIfValid", 32'(ifValid), 32'd0);
    checkOutput("rstIfPc", ifPc, 32'h0);
    checkOutput("rstIfInstr", ifInstr, NOP_INSTR);
    checkOutput("rstReqValid", 32'(reqValid), 32'd0);
  endtask

  task automatic runUntil(input int count, input int budget, input bit rndIf, input int redirPct);
    int target;
    int n;
    logic rdy;
    logic rd;
    target = delivered + count;
    n = 0;
    while (delivered < target && n < budget) begin
      rdy = rndIf ? ($urandom_range(0, 99) < 70) : 1'b1;
      rd  = (redirPct > 0) && ($urandom_range(0, 99) < redirPct);
      applyStimulus(rdy, rd, $urandom() & 32'h0000_FFFF);
      n++;
    end
    checkOutput("deliveredCount", 32'(delivered >= target), 32'd1);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    vecs[1]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
    vecs[2]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h00};
    vecs[3]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h04};
    vecs[4]  = '{1'b1, 1'b1, 32'h0C, 1'b0, 32'h00};
    vecs[5]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h08};
    vecs[6]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h0C};
    vecs[7]  = '{1'b0, 1'b1, 32'h14, 1'b0, 32'h00};
    for (int i = 8; i <= 12; i++) vecs[i] = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h10};
    vecs[13] = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h10};
    vecs[14] = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h14};
    vecs[15] = '{1'b1, 1'b1, 32'h1C, 1'b0, 32'h00};

    $display("[TB] reset and directed stream with 1-cycle memory");
    doReset();
    memRandom = 1'b0;
    memDelay  = 1;
    for (int i = 0; i < 16; i++) begin
      if (i == 7) reqAccepts = 0;
      applyStimulus(vecs[i].ifRdy, 1'b0, 32'h0);
      checkOutput($sformatf("vec%0d.reqValid", i), 32'(reqValid), 32'(vecs[i].expReqValid));
      if (vecs[i].expReqValid) checkOutput($sformatf("vec%0d.reqAddr", i), reqAddr, vecs[i].expReqAddr);
      checkOutput($sformatf("vec%0d.ifValid", i), 32'(ifValid), 32'(vecs[i].expIfValid));
      if (vecs[i].expIfValid) checkOutput($sformatf("vec%0d.ifPc", i), ifPc, vecs[i].expIfPc);
      if (i == 12) checkOutput("stallAcceptsWithinDepth", 32'(reqAccepts <= DEPTH), 32'd1);
    end
    runUntil(6, 100, 1'b0, 0);

    $display("[TB] redirect with two requests in flight");
    doReset();
    memDelay = 3;
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("inflightAtRedirect", 32'(memQ.size()), 32'd2);
    applyStimulus(1'b1, 1'b1, 32'h0000_0100);
    runUntil(4, 100, 1'b0, 0);

    $display("[TB] redirect coinciding with a response");
    doReset();
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h0000_0203);
    checkOutput("rspAtRedirect", 32'(rspValid), 32'd1);
    runUntil(4, 100, 1'b0, 0);

    $display("[TB] random memory ready/latency and ID stalls");
    doReset();
    memRandom = 1'b1;
    runUntil(200, 5000, 1'b1, 0);
    runUntil(100, 5000, 1'b1, 3);

    $display("[TB] PC wrap and mid-stream reset");
    memRandom = 1'b0;
    memDelay  = 1;
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFC);
    runUntil(3, 100, 1'b0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'h0);
    doReset();
    runUntil(3, 100, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
